// File: rtl/bht_update_queue_pkg.sv
// Types shared by the branch-history update queue: the update record handed to
// the BHT and the entry held in the queue. Layout mirrors ariane_pkg::bht_update_t.
package bht_update_queue_pkg;

  localparam int unsigned VLEN = 64;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_entry_t;

  localparam int unsigned BHT_UPDATE_W = $bits(bht_update_t);

endpackage

// File: rtl/bht_update_queue.sv
// Small FIFO that buffers resolved conditional-branch outcomes until the BHT
// accepts them. It counts the updates it drops when full.
module bht_update_queue
  import bht_update_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         debug_mode_i,
  input  logic                         resolved_valid_i,
  input  logic [VLEN-1:0]              resolved_pc_i,
  input  logic                         resolved_taken_i,
  input  logic                         resolved_is_cond_i,
  input  logic                         bht_ready_i,
  output logic [BHT_UPDATE_W-1:0]      bht_update_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [7:0]                   overflow_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  bht_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       ovf_q, ovf_d;

  logic        push_req, pop, full, push, drop;
  bht_update_t upd;

  assign push_req = resolved_valid_i & resolved_is_cond_i & ~debug_mode_i & ~flush_i;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop      = (count_q != '0) & bht_ready_i;
  // A full queue still accepts a new entry when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; the output masks it whenever the
  // queue is empty, so stale contents are never observable.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: resolved_pc_i, taken: resolved_taken_i};
  end

  always_comb begin
    upd       = '0;
    upd.valid = (count_q != '0);
    if (upd.valid) begin
      upd.pc    = mem_q[rd_ptr_q].pc;
      upd.taken = mem_q[rd_ptr_q].taken;
    end
  end

  assign bht_update_o   = upd;
  assign count_o        = count_q;
  assign overflow_cnt_o = ovf_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// Self-checking bench for bht_update_queue: a per-cycle vector table with
// expected occupancy/drop count, plus a scoreboard queue for the drained data.
module tb_bht_update_queue;
  import bht_update_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    flush_i = 1'b0;
  logic                    debug_mode_i = 1'b0;
  logic                    resolved_valid_i = 1'b0;
  logic [VLEN-1:0]         resolved_pc_i = '0;
  logic                    resolved_taken_i = 1'b0;
  logic                    resolved_is_cond_i = 1'b0;
  logic                    bht_ready_i = 1'b0;
  logic [BHT_UPDATE_W-1:0] bht_update_o;
  logic [CNT_W-1:0]        count_o;
  logic [7:0]              overflow_cnt_o;

  bht_update_queue #(.DEPTH(DEPTH)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .debug_mode_i       (debug_mode_i),
    .resolved_valid_i   (resolved_valid_i),
    .resolved_pc_i      (resolved_pc_i),
    .resolved_taken_i   (resolved_taken_i),
    .resolved_is_cond_i (resolved_is_cond_i),
    .bht_ready_i        (bht_ready_i),
    .bht_update_o       (bht_update_o),
    .count_o            (count_o),
    .overflow_cnt_o     (overflow_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, dbg, vld, cond;
    logic [15:0] pc;
    logic        tkn, rdy;
    logic        acc;      // entry expected to be accepted into the queue
    int          exp_cnt;  // count_o after the edge
    int          exp_ovf;  // overflow_cnt_o after the edge
  } vec_t;

  vec_t       vecs[$];
  bht_entry_t sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic vec_t mk(logic rst, logic flush, logic dbg, logic vld, logic cond,
                              logic [15:0] pc, logic tkn, logic rdy, logic acc,
                              int exp_cnt, int exp_ovf);
    vec_t v;
    v.rst = rst; v.flush = flush; v.dbg = dbg; v.vld = vld; v.cond = cond;
    v.pc = pc; v.tkn = tkn; v.rdy = rdy; v.acc = acc;
    v.exp_cnt = exp_cnt; v.exp_ovf = exp_ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [VLEN-1:0] actual,
                       input logic [VLEN-1:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    bht_update_t u;
    @(negedge clk);
    rst_i              = v.rst;
    flush_i            = v.flush;
    debug_mode_i       = v.dbg;
    resolved_valid_i   = v.vld;
    resolved_is_cond_i = v.cond;
    resolved_pc_i      = VLEN'(v.pc);
    resolved_taken_i   = v.tkn;
    bht_ready_i        = v.rdy;
    if (v.rst || v.flush) begin
      sb.delete();
    end else begin
      if (v.rdy && sb.size() != 0) void'(sb.pop_front());
      if (v.acc) sb.push_back('{pc: VLEN'(v.pc), taken: v.tkn});
    end
    @(posedge clk);
    #1;
    u = bht_update_o;
    check($sformatf("count[%0d]", idx), VLEN'(count_o), VLEN'(v.exp_cnt));
    check($sformatf("ovf[%0d]", idx), VLEN'(overflow_cnt_o), VLEN'(v.exp_ovf));
    check($sformatf("valid[%0d]", idx), VLEN'(u.valid), VLEN'(sb.size() != 0));
    if (sb.size() != 0) begin
      check($sformatf("head_pc[%0d]", idx), u.pc, sb[0].pc);
      check($sformatf("head_taken[%0d]", idx), VLEN'(u.taken), VLEN'(sb[0].taken));
    end else begin
      check($sformatf("empty_zero[%0d]", idx), VLEN'(u.pc) | VLEN'(u.taken),
            VLEN'(0));
    end
  endtask

  initial begin
    // reset, then single enqueue with ready high: no same-cycle bypass
    vecs.push_back(mk(1,0,0,0,0,16'h0000,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,1,1,16'h0100,1,1, 1,1,0));
    vecs.push_back(mk(0,0,0,0,0,16'h0000,0,1, 0,0,0));
    // fill with ready low, fifth entry dropped
    vecs.push_back(mk(0,0,0,1,1,16'h0200,1,0, 1,1,0));
    vecs.push_back(mk(0,0,0,1,1,16'h0204,0,0, 1,2,0));
    vecs.push_back(mk(0,0,0,1,1,16'h0208,1,0, 1,3,0));
    vecs.push_back(mk(0,0,0,1,1,16'h020c,0,0, 1,4,0));
    vecs.push_back(mk(0,0,0,1,1,16'h0210,1,0, 0,4,1));
    // full with simultaneous enqueue and dequeue, then drain
    vecs.push_back(mk(0,0,0,1,1,16'h0214,1,1, 1,4,1));
    vecs.push_back(mk(0,0,0,0,0,16'h0000,0,1, 0,3,1));
    vecs.push_back(mk(0,0,0,0,0,16'h0000,0,1, 0,2,1));
    vecs.push_back(mk(0,0,0,0,0,16'h0000,0,1, 0,1,1));
    vecs.push_back(mk(0,0,0,0,0,16'h0000,0,1, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,16'h0000,0,1, 0,0,1));
    // three entries then flush with a same-cycle enqueue
    vecs.push_back(mk(0,0,0,1,1,16'h0300,1,0, 1,1,1));
    vecs.push_back(mk(0,0,0,1,1,16'h0304,0,0, 1,2,1));
    vecs.push_back(mk(0,0,0,1,1,16'h0308,1,0, 1,3,1));
    vecs.push_back(mk(0,1,0,1,1,16'h030c,1,1, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,16'h0000,0,1, 0,0,1));
    // debug mode blocks enqueue but not drain; non-conditional never enqueued
    vecs.push_back(mk(0,0,0,1,1,16'h0400,1,0, 1,1,1));
    vecs.push_back(mk(0,0,0,1,1,16'h0404,0,0, 1,2,1));
    vecs.push_back(mk(0,0,1,1,1,16'h0408,1,1, 0,1,1));
    vecs.push_back(mk(0,0,1,1,1,16'h040c,0,1, 0,0,1));
    vecs.push_back(mk(0,0,0,1,0,16'h0500,1,0, 0,0,1));
    vecs.push_back(mk(0,0,0,1,0,16'h0504,1,1, 0,0,1));
    vecs.push_back(mk(0,0,1,1,1,16'h0508,1,0, 0,0,1));

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // saturation: fill, then 300 drops starting from an overflow count of 1
    for (int i = 0; i < 4; i++)
      apply_vec(mk(0,0,0,1,1,16'h0600 + 16'(4*i),i[0],0, 1,i+1,1), 100 + i);
    for (int i = 0; i < 300; i++)
      apply_vec(mk(0,0,0,1,1,16'h0700,1,0, 0,4,(i + 2 > 255) ? 255 : i + 2), 200 + i);
    check("ovf_saturated", VLEN'(overflow_cnt_o), VLEN'(255));

    // reset mid-stream wins over a same-cycle enqueue and dequeue
    apply_vec(mk(1,0,0,1,1,16'h0900,1,1, 0,0,0), 600);
    check("post_reset_update", VLEN'(bht_update_o), VLEN'(0));
    apply_vec(mk(0,0,0,1,1,16'h0a00,0,1, 1,1,0), 601);
    apply_vec(mk(0,0,0,0,0,16'h0000,0,1, 0,0,0), 602);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
